// File: rtl/sevseg_pkg.sv
// Shared types and constants for the two-digit seven-segment multiplexer.
//   mux_state_t : display phase (two show phases, two blanking phases)
//   AN_*        : active-low common-anode enable patterns
//   cnt_width   : phase counter width for a given pair of phase lengths
package sevseg_pkg;

  typedef enum logic [1:0] {
    SHOW0  = 2'd0,
    BLANK0 = 2'd1,
    SHOW1  = 2'd2,
    BLANK1 = 2'd3
  } mux_state_t;

  localparam logic [1:0] AN_OFF = 2'b11;
  localparam logic [1:0] AN_D0  = 2'b10;
  localparam logic [1:0] AN_D1  = 2'b01;

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2((a > b) ? a : b);
  endfunction

endpackage

// File: rtl/sevseg_mux_if.sv
// Digit/display bundle for sevseg_mux.
//   d0, d1 : hex digits to show (driven by master)
//   s      : hex value towards the segment decoder
//   an     : active-low anode enables, an[0] = digit 0
//   sel    : current/last digit index
//   blank  : high while both digits are dark
interface sevseg_mux_if;
  logic [3:0] d0;
  logic [3:0] d1;
  logic [3:0] s;
  logic [1:0] an;
  logic       sel;
  logic       blank;

  modport master (output d0, output d1, input s, input an, input sel, input blank);
  modport slave  (input d0, input d1, output s, output an, output sel, output blank);
endinterface

// File: rtl/sevseg_mux_phase_counter.sv
// Terminal-count phase counter. Counts 0..term_i, then wraps to 0 on the
// edge where count equals term_i; done_o flags that terminal cycle.
//   clk, rst_n : clock, async active-low reset (count -> 0)
//   term_i     : terminal value (phase length - 1)
//   count_o    : current count
//   done_o     : high during the last cycle of the phase
module phase_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] count_o,
  output logic         done_o
);

  logic [W-1:0] count_q, count_d;

  assign done_o  = (count_q == term_i);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q + W'(1);
    if (done_o) count_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/sevseg_mux.sv
// Two-digit seven-segment time multiplexer with inter-digit blanking.
// Cycles SHOW0 -> BLANK0 -> SHOW1 -> BLANK1, each show phase DIV_CYCLES
// clocks and each blank phase BLANK_CYCLES clocks. All outputs are
// registered and change on the edge that enters a phase.
//   clk   : system clock
//   reset : asynchronous active-low reset (0 = reset asserted)
//   io    : digit inputs and display outputs (slave side)
module sevseg_mux
  import sevseg_pkg::*;
#(
  parameter int unsigned DIV_CYCLES   = 24000,
  parameter int unsigned BLANK_CYCLES = 240
) (
  input logic          clk,
  input logic          reset,
  sevseg_mux_if.slave  io
);

  if (DIV_CYCLES < 2) begin : g_div_chk
    $error("sevseg_mux: DIV_CYCLES must be >= 2");
  end
  if (BLANK_CYCLES < 1) begin : g_blank_chk
    $error("sevseg_mux: BLANK_CYCLES must be >= 1");
  end

  localparam int unsigned   CW         = cnt_width(DIV_CYCLES, BLANK_CYCLES);
  localparam logic [CW-1:0] DIV_TERM   = CW'(DIV_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_TERM = CW'(BLANK_CYCLES - 1);

  mux_state_t    state_q, state_d;
  logic [CW-1:0] term;
  logic [CW-1:0] count;
  logic          done;

  logic [3:0] s_q, s_d;
  logic [1:0] an_q, an_d;
  logic       sel_q, sel_d;
  logic       blank_q, blank_d;

  assign term = (state_q == SHOW0 || state_q == SHOW1) ? DIV_TERM : BLANK_TERM;

  // Counter wraps by itself on done, which is exactly the phase boundary.
  phase_counter #(.W(CW)) u_phase (
    .clk     (clk),
    .rst_n   (reset),
    .term_i  (term),
    .count_o (count),
    .done_o  (done)
  );

  always_comb begin
    state_d = state_q;
    if (done) begin
      case (state_q)
        SHOW0:   state_d = BLANK0;
        BLANK0:  state_d = SHOW1;
        SHOW1:   state_d = BLANK1;
        BLANK1:  state_d = SHOW0;
        default: state_d = BLANK1;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register on the
  // entry edge; s captures a digit only on a show-phase entry.
  always_comb begin
    s_d     = s_q;
    an_d    = AN_OFF;
    sel_d   = 1'b1;
    blank_d = 1'b1;
    case (state_d)
      SHOW0: begin
        an_d    = AN_D0;
        sel_d   = 1'b0;
        blank_d = 1'b0;
        if (done) s_d = io.d0;
      end
      BLANK0: begin
        sel_d = 1'b0;
      end
      SHOW1: begin
        an_d    = AN_D1;
        blank_d = 1'b0;
        if (done) s_d = io.d1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BLANK1;
      s_q     <= '0;
      an_q    <= AN_OFF;
      sel_q   <= 1'b1;
      blank_q <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      an_q    <= an_d;
      sel_q   <= sel_d;
      blank_q <= blank_d;
    end
  end

  assign io.s     = s_q;
  assign io.an    = an_q;
  assign io.sel   = sel_q;
  assign io.blank = blank_q;

  logic unused_count;
  assign unused_count = ^count;

endmodule
